// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and lane helper for the load/store unit.
package lsu_pkg;

    // RV32I load/store width codes carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Store read-modify-write sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RMW_RD = 2'b01,
        RMW_WR = 2'b10
    } lsu_state_e;

    // Bit mask covering the byte or halfword lane that a sub-word store replaces
    function automatic logic [31:0] lane_mask(input logic is_half, input logic [1:0] lane);
        logic [31:0] base_v;
        if (is_half) begin
            base_v = 32'h0000_FFFF;
        end else begin
            base_v = 32'h0000_00FF;
        end
        return base_v << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign/zero extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: bytes by addr[1:0], halfwords by addr[1]
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (lane)
            2'b00:   byte_s = mem_rd[7:0];
            2'b01:   byte_s = mem_rd[15:8];
            2'b10:   byte_s = mem_rd[23:16];
            2'b11:   byte_s = mem_rd[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = mem_rd[31:16];
        end else begin
            half_s = mem_rd[15:0];
        end
    end

    // Width-dependent extension; illegal codes read as zero
    always_comb begin
        rdata = 32'h0000_0000;
        case (funct3)
            F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata = {{16{half_s[15]}}, half_s};
            F3_W:    rdata = mem_rd;
            F3_BU:   rdata = {24'h00_0000, byte_s};
            F3_HU:   rdata = {16'h0000, half_s};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-wide memory port, zero-latency loads and SW,
// two-cycle read-modify-write for SB/SH, misaligned/illegal accesses blocked.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           funct3,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      wdata,
    output logic                 req_ready,
    output logic [XLEN-1:0]      rdata,
    output logic                 rvalid,
    output logic                 misalign,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [XLEN-1:0]      mem_a,
    output logic [XLEN-1:0]      mem_wd,
    output logic                 mem_we,
    input  logic [XLEN-1:0]      mem_rd
);

    lsu_state_e          state_r;
    lsu_state_e          next_state_s;
    logic                is_half_s;
    logic                is_word_s;
    logic                illegal_s;
    logic                misaligned_s;
    logic                start_rmw_s;
    logic [XLEN-1:0]     load_data_s;
    logic [XLEN-1:0]     mask_s;
    logic [XLEN-1:0]     merged_s;
    logic [XLEN-1:0]     waddr_r;
    logic [1:0]          lane_r;
    logic [XLEN-1:0]     wdata_r;
    logic                half_r;
    logic [XLEN-1:0]     buf_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Request decode: width class, illegal codes and alignment
    always_comb begin
        is_half_s    = (funct3[1:0] == 2'b01);
        is_word_s    = (funct3[1:0] == 2'b10);
        illegal_s    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned_s = 1'b0;
        if (illegal_s) begin
            misaligned_s = 1'b1;
        end else if (is_half_s) begin
            misaligned_s = addr[0];
        end else if (is_word_s) begin
            misaligned_s = (addr[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
        start_rmw_s = (state_r == IDLE) && req_valid && req_we && !misaligned_s && !is_word_s;
    end

    lsu_load_align u_load_align (
        .mem_rd (mem_rd),
        .lane   (addr[1:0]),
        .funct3 (funct3),
        .rdata  (load_data_s)
    );

    // Sub-word merge of latched store data into the word read back
    always_comb begin
        mask_s   = lane_mask(half_r, lane_r);
        merged_s = (buf_r & ~mask_s) | ((wdata_r << {lane_r, 3'b000}) & mask_s);
    end

    // State register; reset aborts any RMW in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state: sub-word stores take the two-cycle RMW detour
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_rmw_s) begin
                    next_state_s = RMW_RD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RMW_RD:  next_state_s = RMW_WR;
            RMW_WR:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Outputs: memory port control and load response
    always_comb begin
        req_ready = 1'b0;
        rvalid    = 1'b0;
        misalign  = 1'b0;
        rdata     = 32'h0000_0000;
        mem_a     = {addr[XLEN-1:2], 2'b00};
        mem_wd    = 32'h0000_0000;
        mem_we    = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (!req_valid) begin
                    rvalid = 1'b0;
                end else if (misaligned_s) begin
                    misalign = 1'b1;
                end else if (!req_we) begin
                    rvalid = 1'b1;
                    rdata  = load_data_s;
                end else if (is_word_s) begin
                    mem_we = 1'b1;
                    mem_wd = wdata;
                end else begin
                    mem_we = 1'b0;
                end
            end
            RMW_RD: begin
                mem_a = waddr_r;
            end
            RMW_WR: begin
                mem_a  = waddr_r;
                mem_we = 1'b1;
                mem_wd = merged_s;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Capture address, lane, data and width of an accepted SB/SH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_r <= 32'h0000_0000;
            lane_r  <= 2'b00;
            wdata_r <= 32'h0000_0000;
            half_r  <= 1'b0;
        end else if (start_rmw_s) begin
            waddr_r <= {addr[XLEN-1:2], 2'b00};
            lane_r  <= is_half_s ? {addr[1], 1'b0} : addr[1:0];
            wdata_r <= wdata;
            half_r  <= is_half_s;
        end
    end

    // Merge buffer holds the old word read during RMW_RD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r <= 32'h0000_0000;
        end else if (state_r == RMW_RD) begin
            buf_r <= mem_rd;
        end
    end

    // Saturating count of rejected (misaligned/illegal) requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if ((state_r == IDLE) && req_valid && misaligned_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + 1'b1;
        end
    end

    assign err_cnt = err_cnt_r;

endmodule
